// File: rtl/gmem_arbiter_if.sv
// Requester/memory bundle of the graph_memory read-port arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface gmem_arbiter_if #(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic [NUM_REQ-1:0]    req_valid_in;
   logic [ADDR_WIDTH-1:0] req_addr_in [NUM_REQ];
   logic [NUM_REQ-1:0]    req_last_in;
   logic [NUM_REQ-1:0]    req_ready_out;
   logic [DATA_WIDTH-1:0] resp_data_out;
   logic [NUM_REQ-1:0]    resp_valid_out;
   logic [ADDR_WIDTH-1:0] mem_req_out;
   logic                  mem_valid_out;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic                  mem_valid_in;
   logic [CNT_W-1:0]      outstanding_out;
   logic                  busy_out;
   logic                  err_out;

   modport slave (
      input  req_valid_in, req_addr_in, req_last_in, mem_data_in, mem_valid_in,
      output req_ready_out, resp_data_out, resp_valid_out, mem_req_out, mem_valid_out,
             outstanding_out, busy_out, err_out
   );

   modport master (
      output req_valid_in, req_addr_in, req_last_in, mem_data_in, mem_valid_in,
      input  req_ready_out, resp_data_out, resp_valid_out, mem_req_out, mem_valid_out,
             outstanding_out, busy_out, err_out
   );
endinterface

// File: rtl/gmem_arbiter.sv
// Round-robin arbiter with packet locking that shares one graph_memory read port
// among NUM_REQ engines; an in-order tag FIFO steers responses back to their issuer.
module gmem_arbiter #(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input logic            clk_in,
   input logic            rst_in,
   gmem_arbiter_if.slave  bus
);
   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   typedef enum logic [0:0] {IDLE, LOCKED} state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]      owner_q, owner_d;
   logic [IDX_W-1:0]      grant_idx, acc_idx;
   logic                  grant_found, credit_ok, accept, acc_last, pop, err_ret;
   logic [NUM_REQ-1:0]    ready_c, head_onehot;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [CNT_W-1:0]      outstanding_q, outstanding_d;
   logic [IDX_W-1:0]      tag_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;

   // First valid requester after rr_ptr, wrapping (NUM_REQ is a power of two).
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         if (!grant_found && bus.req_valid_in[rr_ptr_q + IDX_W'(k)]) begin
            grant_found = 1'b1;
            grant_idx   = rr_ptr_q + IDX_W'(k);
         end
      end
   end

   assign credit_ok = (outstanding_q != CNT_MAX);

   // Next-state and grant; a locked packet keeps the port until its last beat.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      ready_c  = '0;
      acc_idx  = grant_idx;
      unique case (state_q)
         IDLE: begin
            acc_idx = grant_idx;
            if (credit_ok && grant_found) ready_c[grant_idx] = 1'b1;
         end
         LOCKED: begin
            acc_idx = owner_q;
            if (credit_ok) ready_c[owner_q] = 1'b1;
         end
         default: ;
      endcase
      accept   = |(ready_c & bus.req_valid_in);
      acc_last = bus.req_last_in[acc_idx];
      acc_addr = bus.req_addr_in[acc_idx];
      if (accept) begin
         unique case (state_q)
            IDLE: begin
               if (acc_last) begin
                  rr_ptr_d = acc_idx;
               end else begin
                  state_d = LOCKED;
                  owner_d = acc_idx;
               end
            end
            LOCKED: begin
               if (acc_last) begin
                  state_d  = IDLE;
                  rr_ptr_d = owner_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready_out = rst_in ? ready_c : '0;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= IDLE;
         rr_ptr_q <= IDX_W'(NUM_REQ - 1);
         owner_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
      end
   end

   // FIFO occupancy equals the credit count, so empty means outstanding == 0.
   assign pop     = bus.mem_valid_in && (outstanding_q != '0);
   assign err_ret = bus.mem_valid_in && (outstanding_q == '0);

   always_comb begin
      outstanding_d = outstanding_q;
      if (accept && !pop)      outstanding_d = outstanding_q + CNT_W'(1);
      else if (!accept && pop) outstanding_d = outstanding_q - CNT_W'(1);
   end

   always_comb begin
      head_onehot = '0;
      head_onehot[tag_mem[rd_ptr_q]] = 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (accept) tag_mem[wr_ptr_q] <= acc_idx;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr_q            <= '0;
         rd_ptr_q            <= '0;
         outstanding_q       <= '0;
         bus.mem_valid_out   <= 1'b0;
         bus.mem_req_out     <= '0;
         bus.resp_valid_out  <= '0;
         bus.resp_data_out   <= '0;
         bus.outstanding_out <= '0;
         bus.busy_out        <= 1'b0;
         bus.err_out         <= 1'b0;
      end else begin
         if (accept) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
         if (pop)    rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
         outstanding_q       <= outstanding_d;
         bus.outstanding_out <= outstanding_d;
         bus.busy_out        <= (outstanding_d != '0) || (state_d == LOCKED);
         bus.mem_valid_out   <= accept;
         bus.mem_req_out     <= accept ? acc_addr : '0;
         bus.resp_valid_out  <= pop ? head_onehot : '0;
         if (pop)     bus.resp_data_out <= bus.mem_data_in;
         if (err_ret) bus.err_out       <= 1'b1;
      end
   end
endmodule

// File: doc/gmem_arbiter.md
Name: gmem_arbiter

Overview:
- Shares one graph_memory read port among NUM_REQ graph_fetch/bfis search engines, so parallel query engines can run against one graph image.
- Performs round-robin arbitration with packet locking, so a multi-word fetch (DIM position words or a neighbour list) is never interleaved with another engine's fetch.
- Tracks in-flight request owners in an in-order tag FIFO and steers each memory response back to the requester that issued it.
- Bounds outstanding reads with a credit counter.

Parameters:
- NUM_REQ, 4: number of requesters (power of 2, ≥2).
- ADDR_WIDTH, 32: memory address width.
- DATA_WIDTH, 32: memory word width.
- MAX_OUTSTANDING, 4: maximum accepted-but-unanswered reads; also the tag FIFO depth.

Ports:
- clk_in, input, 1: the single clock; all logic is on its rising edge.
- rst_in, input, 1: reset, asynchronous assert, active-low (0 = reset).
- req_valid_in, input, NUM_REQ: per-requester read request valid.
- req_addr_in, input, ADDR_WIDTH x NUM_REQ: unpacked array; per-requester address.
- req_last_in, input, NUM_REQ: beat is the last of its packet; a single read has last=1.
- req_ready_out, output, NUM_REQ: combinational grant; a beat is accepted when valid & ready are both high at a clock edge.
- resp_data_out, output, DATA_WIDTH: response data, broadcast to all requesters.
- resp_valid_out, output, NUM_REQ: one-hot; marks which requester owns resp_data_out.
- mem_req_out, output, ADDR_WIDTH: address to graph_memory.
- mem_valid_out, output, 1: read strobe to graph_memory.
- mem_data_in, input, DATA_WIDTH: read data from graph_memory.
- mem_valid_in, input, 1: read data valid; responses return in issue order.
- outstanding_out, output, clog2(MAX_OUTSTANDING)+1: current credit usage.
- busy_out, output, 1: high when outstanding_out != 0 or state is LOCKED.
- err_out, output, 1: sticky; set when mem_valid_in arrives while the tag FIFO is empty.

Behaviour:
- Reset (rst_in=0, asynchronous), all outputs and state clear:
  - req_ready_out=0, resp_valid_out=0, resp_data_out=0, mem_valid_out=0, mem_req_out=0.
  - outstanding_out=0, busy_out=0, err_out=0.
  - Tag FIFO empty, state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation discards all in-flight tags.
  - graph_memory shares the reset, so no stale returns are expected.
  - Any return that does arrive sets err_out.
- Credit gate: no req_ready_out bit is asserted while outstanding == MAX_OUTSTANDING. There is no same-cycle bypass from a returning response.
- States:
  - IDLE:
    - req_ready_out is one-hot, or all zero if no request is valid or credits are exhausted.
    - The granted requester is the first i with req_valid_in[i]=1, searching (rr_ptr+1) mod NUM_REQ upward with wrap.
    - Accepted beat with last=1: stay IDLE; rr_ptr <= granted index.
    - Accepted beat with last=0: go to LOCKED; owner <= granted index.
  - LOCKED:
    - Only owner may be ready (subject to credits); all other ready bits stay 0 even if their valid is high.
    - Owner beat accepted with last=1: go to IDLE; rr_ptr <= owner.
    - Owner beat accepted with last=0: stay LOCKED.
    - The owner dropping valid does not release the lock.
- Issue: on acceptance at edge t, mem_valid_out=1 and mem_req_out=addr during cycle t+1 only (registered, one cycle). The owner index is pushed to the tag FIFO at edge t.
- Maximum throughput is one beat per cycle, including back-to-back beats from different requesters in IDLE.
- Return: on mem_valid_in at edge t, with the FIFO non-empty:
  - Pop the head tag h.
  - During cycle t+1, resp_data_out=mem_data_in and resp_valid_out[h]=1; otherwise resp_valid_out=0.
  - resp_data_out holds its last value when no response is valid.
- Counter:
  - outstanding increments on accept and decrements on a valid return.
  - Accept and return in the same cycle leave it unchanged.
  - It never exceeds MAX_OUTSTANDING and never underflows; an error return leaves it unchanged.
- No combinational path from mem_* inputs to mem_* outputs. The req_valid_in → req_ready_out path is combinational.

Test Plan:
1. Single read:
   - Stimulus: after reset, req 2 valid, addr 0x40, last=1.
   - Required: ready_out=4'b0100 in the same cycle; mem_valid_out and mem_req_out=0x40 the next cycle.
   - Then memory returns 0xDEAD: resp_valid_out=4'b0100 with data 0xDEAD one cycle later; outstanding goes 0→1→0.
2. Round-robin fairness:
   - Stimulus: all four requesters hold valid, single-beat, for 8 cycles.
   - Required: grant order 0,1,2,3,0,1,2,3, with no requester granted twice before the others.
3. Packet lock:
   - Stimulus: req 1 sends a 2-beat packet (0x100 last=0, 0x101 last=1) with a one-cycle valid gap; req 0 stays valid throughout.
   - Required: req 0 gets no ready until 0x101 is accepted; req 0 is granted on the next cycle; mem_req_out sequence is 0x100, 0x101, then req 0's address.
4. Credit stall:
   - Stimulus: MAX_OUTSTANDING=4, memory withholds returns, req 3 streams 6 single beats.
   - Required: exactly 4 accepted, then ready drops and outstanding_out=4; each subsequent return re-enables exactly one accept.
5. Out-of-owner return steering:
   - Stimulus: interleave accepts from req 0, 3, 1; memory returns A, B, C.
   - Required: resp_valid_out sequence 0001 (data A), 1000 (B), 0010 (C).
   - Also: accept and return in the same cycle leaves outstanding unchanged.
6. Error and reset:
   - Stimulus: mem_valid_in with an empty FIFO → err_out=1 sticky, no resp_valid_out.
   - Stimulus: rst_in low mid-packet in LOCKED state → all outputs 0 asynchronously; after release, state is IDLE and requester 0 has priority.
